serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial WIDTH-bit adder built around the team's single-bit `fulladder` cell. It sits directly upstream of that cell and drives it. Operands are captured on a start handshake, fed LSB-first through one `fulladder` instance, one bit per clock, with the carry held in a flip-flop between bits. It trades the area of a WIDTH-wide ripple adder for WIDTH cycles of latency, and reports completion with a one-cycle `done` pulse.

## Interface
- `WIDTH`, default 8: operand and sum width in bits. Legal values are WIDTH ≥ 1.
- `clk` input, 1 bit: single clock. All state changes on the rising edge.
- `rst` input, 1 bit: reset, asynchronous and active-high.
- `start` input, 1 bit: request a new addition. Sampled only in IDLE or DONE.
- `a` input, WIDTH bits: operand A. Captured on an accepted start.
- `b` input, WIDTH bits: operand B. Captured on an accepted start.
- `cin` input, 1 bit: carry-in. Captured on an accepted start.
- `busy` output, 1 bit: high while in RUN.
- `done` output, 1 bit: high for exactly the one cycle spent in DONE.
- `sum` output, WIDTH bits: registered result. Holds its value until the next completion.
- `cout` output, 1 bit: registered carry-out of the MSB. Updates together with `sum`.

## Operation
- FSM states are IDLE, RUN and DONE. Internal state:
  - operand shift registers `sa` and `sb`
  - result shift register `sr`
  - carry flip-flop `c`
  - bit counter `cnt`, wide enough for 0..WIDTH-1
- Reset (asynchronous, any state) sets:
  - state = IDLE
  - `sa` = `sb` = `sr` = 0, `c` = 0, `cnt` = 0
  - outputs `sum` = 0, `cout` = 0, `busy` = 0, `done` = 0
- IDLE or DONE, with `start` = 1 at the edge:
  - `sa` ← `a`, `sb` ← `b`, `c` ← `cin`, `cnt` ← 0
  - state → RUN
- IDLE with `start` = 0: remain in IDLE.
- DONE with `start` = 0: state → IDLE.
- RUN, each edge:
  - The `fulladder` inputs are `sa[0]`, `sb[0]` and `c`.
  - `sr` ← {s, `sr[WIDTH-1:1]`}, shifting the result in MSB-first so the LSB lands at bit 0 after WIDTH shifts.
  - `sa` and `sb` shift right by one.
  - `c` ← cout of the cell.
  - `cnt` ← `cnt` + 1.
- RUN with `cnt` == WIDTH-1 (the last bit):
  - `sum` ← {s, `sr[WIDTH-1:1]`}, `cout` ← cell cout
  - state → DONE
- `start` during RUN is ignored. `a`, `b` and `cin` changes during RUN have no effect.
- Arithmetic: {`cout`, `sum`} = `a` + `b` + `cin`, modulo 2^(WIDTH+1). There is no overflow flag; the extra bit is `cout`.
- WIDTH = 1: RUN lasts one edge, so the path is IDLE → RUN → DONE.
- Reset in RUN aborts the operation. No `done` is produced, and `sum`/`cout` clear to 0.

## Timing
- Let E0 be the edge where `start` is accepted.
- RUN processes bit k at edge E(k+1), for k = 0..WIDTH-1.
- `sum`, `cout` and `done` become valid together after edge E(WIDTH). Latency is WIDTH cycles from the accepting edge.
- `busy` is high from after E0 through E(WIDTH), i.e. WIDTH cycles.
- `done` is high for the one cycle after E(WIDTH).
- If `start` = 1 at E(WIDTH+1), the next operation is accepted back-to-back. Maximum throughput is one addition per WIDTH+1 cycles.
- `done` never stays high for two consecutive cycles.
- `sum` and `cout` are stable except at completion edges and reset.
- `busy` and `done` are decoded from registered state. No combinational path runs from inputs to outputs.

## Test plan
1. Basic add, WIDTH=8: `a`=0x3C, `b`=0x5A, `cin`=0, start pulsed one cycle. Expect `busy` high for 8 cycles, then `done` for 1 cycle with `sum`=0x96, `cout`=0. `sum` holds 0x96 afterwards.
2. Full carry ripple: `a`=0xFF, `b`=0x00, `cin`=1. Expect `sum`=0x00, `cout`=1. Then `a`=0xFF, `b`=0xFF, `cin`=1. Expect `sum`=0xFF, `cout`=1.
3. Back-to-back: hold `start` high continuously, with operand pairs (0x01,0x01,0) then (0x80,0x80,0) presented at each accepting edge.
   - `done` pulses every 9 cycles.
   - Results are 0x02/`cout`=0, then 0x00/`cout`=1.
   - `busy` drops for exactly one cycle between operations.
4. Ignore during RUN: start 0x10+0x20. At RUN cycle 3, drive `start`=1 and `a`=0xAA. Expect a single `done` with `sum`=0x30, and no second operation.
5. Reset mid-operation: start 0x7F+0x01, then assert `rst` during RUN cycle 4.
   - Expect `sum`=0, `cout`=0, `busy`=0 and no `done`.
   - After release, start 0x05+0x03+`cin`=1 and expect `sum`=0x09, `cout`=0.
6. Randomised check against a reference model (WIDTH=8 and WIDTH=1, 1000 ops each, random start gaps): {`cout`,`sum`} = `a`+`b`+`cin` at every `done`, and `done` is never asserted two cycles in a row.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one fulladder cell, one bit per clock LSB-first,
// carry held in a flip-flop between bits, one-cycle done pulse on completion.

module fulladder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sa_q, sa_d, sb_q, sb_d, sr_q, sr_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [WIDTH-1:0]   sr_shift;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               c_q, c_d, cout_q, cout_d;
  logic               fa_s, fa_c;

  fulladder u_fa (
    .a_i (sa_q[0]),
    .b_i (sb_q[0]),
    .c_i (c_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
  assign sr_shift = (sr_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sr_d    = sr_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          c_d     = cin;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sr_d  = sr_shift;
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        c_d   = fa_c;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          sum_d   = sr_shift;
          cout_d  = fa_c;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sr_q    <= sr_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomised bench for serial_adder at WIDTH=8 and WIDTH=1.

module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;
  int         n_cmp = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit w1, input logic [7:0] aa, input logic [7:0] bb,
                        input logic cc, input logic st);
    if (w1) begin
      a1 = aa[0]; b1 = bb[0]; cin1 = cc; start1 = st;
    end else begin
      a8 = aa; b8 = bb; cin8 = cc; start8 = st;
    end
  endtask

  task automatic start_op(input bit w1, input logic [7:0] aa, input logic [7:0] bb,
                          input logic cc);
    set_in(w1, aa, bb, cc, 1'b1);
    tick();
    start8 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_done(input bit w1, output int nb, output bit to);
    int cyc;
    nb  = 0;
    cyc = 0;
    while (!(w1 ? done1 : done8) && cyc < 40) begin
      if (w1 ? busy1 : busy8) nb++;
      tick();
      cyc++;
    end
    to = !(w1 ? done1 : done8);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(0, 8'h00, 8'h00, 1'b0, 1'b0);
    set_in(1, 8'h00, 8'h00, 1'b0, 1'b0);
    tick();
    n_cmp++;
    if ({sum8, cout8, busy8, done8} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset8: got sum=%h cout=%b busy=%b done=%b, want all 0", sum8, cout8, busy8, done8);
    end
    n_cmp++;
    if ({sum1, cout1, busy1, done1} !== 4'd0) begin
      n_fail++;
      $display("FAIL reset1: got sum=%h cout=%b busy=%b done=%b, want all 0", sum1, cout1, busy1, done1);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int nb; bit to;
    start_op(0, 8'h3C, 8'h5A, 1'b0);
    wait_done(0, nb, to);
    n_cmp++;
    if (to) begin n_fail++; $display("FAIL basic_timeout: done not seen, want done within 40 cycles"); end
    n_cmp++;
    if (nb !== 8) begin n_fail++; $display("FAIL basic_busy: busy cycles %0d, want 8", nb); end
    n_cmp++;
    if ({cout8, sum8} !== 9'h096) begin n_fail++; $display("FAIL basic_sum: got %h, want 096", {cout8, sum8}); end
    tick();
    n_cmp++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      n_fail++; $display("FAIL basic_pulse: done=%b busy=%b, want 0 0", done8, busy8);
    end
    repeat (3) tick();
    n_cmp++;
    if (sum8 !== 8'h96) begin n_fail++; $display("FAIL basic_hold: sum %h, want 96", sum8); end
  endtask

  task automatic test_carry();
    int nb; bit to;
    start_op(0, 8'hFF, 8'h00, 1'b1);
    wait_done(0, nb, to);
    n_cmp++;
    if (to || {cout8, sum8} !== 9'h100) begin
      n_fail++; $display("FAIL carry_ff00: got %h timeout=%b, want 100", {cout8, sum8}, to);
    end
    tick();
    start_op(0, 8'hFF, 8'hFF, 1'b1);
    wait_done(0, nb, to);
    n_cmp++;
    if (to || {cout8, sum8} !== 9'h1FF) begin
      n_fail++; $display("FAIL carry_ffff: got %h timeout=%b, want 1ff", {cout8, sum8}, to);
    end
    tick();
  endtask

  task automatic test_width1();
    int nb; bit to;
    start_op(1, 8'h01, 8'h01, 1'b1);
    wait_done(1, nb, to);
    n_cmp++;
    if (to || nb !== 1) begin n_fail++; $display("FAIL w1_busy: busy %0d timeout=%b, want 1 0", nb, to); end
    n_cmp++;
    if ({cout1, sum1} !== 2'b11) begin n_fail++; $display("FAIL w1_111: got %b, want 11", {cout1, sum1}); end
    tick();
    start_op(1, 8'h00, 8'h01, 1'b0);
    wait_done(1, nb, to);
    n_cmp++;
    if (to || {cout1, sum1} !== 2'b01) begin n_fail++; $display("FAIL w1_010: got %b, want 01", {cout1, sum1}); end
    tick();
  endtask

  task automatic test_back_to_back();
    int nb, cyc, blow; bit to;
    set_in(0, 8'h01, 8'h01, 1'b0, 1'b1);
    tick();
    set_in(0, 8'h80, 8'h80, 1'b0, 1'b1);
    wait_done(0, nb, to);
    n_cmp++;
    if (to || {cout8, sum8} !== 9'h002) begin
      n_fail++; $display("FAIL b2b_first: got %h timeout=%b, want 002", {cout8, sum8}, to);
    end
    blow = busy8 ? 0 : 1;
    cyc  = 0;
    do begin
      tick();
      cyc++;
      if (!busy8 && !done8) blow++;
    end while (!done8 && cyc < 20);
    start8 = 1'b0;
    n_cmp++;
    if (cyc !== 9) begin n_fail++; $display("FAIL b2b_period: done spacing %0d, want 9", cyc); end
    n_cmp++;
    if (blow !== 1) begin n_fail++; $display("FAIL b2b_gap: busy low %0d cycles, want 1", blow); end
    n_cmp++;
    if ({cout8, sum8} !== 9'h100) begin n_fail++; $display("FAIL b2b_second: got %h, want 100", {cout8, sum8}); end
    tick();
    n_cmp++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      n_fail++; $display("FAIL b2b_stop: done=%b busy=%b, want 0 0", done8, busy8);
    end
  endtask

  task automatic test_ignore_run();
    int nb, dn, bz; bit to;
    start_op(0, 8'h10, 8'h20, 1'b0);
    tick();
    tick();
    set_in(0, 8'hAA, 8'h20, 1'b0, 1'b1);
    tick();
    start8 = 1'b0;
    wait_done(0, nb, to);
    n_cmp++;
    if (to || {cout8, sum8} !== 9'h030) begin
      n_fail++; $display("FAIL ignore_sum: got %h timeout=%b, want 030", {cout8, sum8}, to);
    end
    dn = 0; bz = 0;
    repeat (20) begin
      tick();
      if (done8) dn++;
      if (busy8) bz++;
    end
    n_cmp++;
    if (dn !== 0 || bz !== 0) begin
      n_fail++; $display("FAIL ignore_extra: extra done %0d busy %0d, want 0 0", dn, bz);
    end
  endtask

  task automatic test_reset_mid();
    int nb, dn; bit to;
    start_op(0, 8'h7F, 8'h01, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({sum8, cout8, busy8, done8} !== 11'd0) begin
      n_fail++; $display("FAIL rstmid_clear: sum=%h cout=%b busy=%b done=%b, want all 0", sum8, cout8, busy8, done8);
    end
    tick();
    rst = 1'b0;
    dn = 0;
    repeat (12) begin
      tick();
      if (done8) dn++;
    end
    n_cmp++;
    if (dn !== 0 || sum8 !== 8'h00) begin
      n_fail++; $display("FAIL rstmid_nodone: done count %0d sum %h, want 0 00", dn, sum8);
    end
    start_op(0, 8'h05, 8'h03, 1'b1);
    wait_done(0, nb, to);
    n_cmp++;
    if (to || nb !== 8 || {cout8, sum8} !== 9'h009) begin
      n_fail++; $display("FAIL rstmid_after: got %h busy %0d timeout=%b, want 009 8 0", {cout8, sum8}, nb, to);
    end
    tick();
  endtask

  task automatic test_random(input bit w1);
    logic [7:0] aa, bb;
    logic       cc;
    logic [8:0] exp, got;
    int         nb, gap;
    bit         to;
    aa = 8'($urandom); bb = 8'($urandom); cc = 1'($urandom);
    start_op(w1, aa, bb, cc);
    for (int i = 0; i < 1000; i++) begin
      exp = w1 ? (9'(aa[0]) + 9'(bb[0]) + 9'(cc)) : (9'(aa) + 9'(bb) + 9'(cc));
      wait_done(w1, nb, to);
      got = w1 ? {7'd0, cout1, sum1} : {cout8, sum8};
      n_cmp++;
      if (to || got !== exp) begin
        n_fail++; $display("FAIL rand_w%0d op %0d: got %h timeout=%b, want %h", w1 ? 1 : 8, i, got, to, exp);
      end
      aa  = 8'($urandom); bb = 8'($urandom); cc = 1'($urandom);
      gap = (i == 999) ? 1 : int'($urandom_range(0, 2));
      if (gap == 0) set_in(w1, aa, bb, cc, 1'b1);
      tick();
      start8 = 1'b0;
      start1 = 1'b0;
      n_cmp++;
      if ((w1 ? done1 : done8) !== 1'b0) begin
        n_fail++; $display("FAIL rand_w%0d double_done op %0d: done=1, want 0", w1 ? 1 : 8, i);
      end
      if (gap != 0 && i != 999) begin
        repeat (gap - 1) tick();
        start_op(w1, aa, bb, cc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_width1();
    test_back_to_back();
    test_ignore_run();
    test_reset_mid();
    test_random(1'b0);
    test_random(1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
